// File: rtl/axi_mem_slave_pkg.sv
// Shared AXI constants and the controller state type for axi_mem_slave.
package axi_mem_slave_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [2:0] AXI_SIZE_4B     = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // Write response code for an accumulated framing error.
    function automatic logic [1:0] resp_for(input logic err);
        return err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_mem_slave_ram.sv
// Simple dual-port word RAM: one synchronous write port, one synchronous
// read port with read enable so the output holds while the reader stalls.
module axi_mem_slave_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [31:0]       wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [0:(1<<ADDR_W)-1];
    logic [31:0] rdata_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port; output only moves when a new word is requested.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 INCR-only memory target, one transaction in flight, 32-bit data.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | both address channels open; AW wins a same-cycle tie
//  RD      | streaming read beats from RAM, one per RREADY handshake
//  WR      | accepting write beats until the latched length is reached
//  RESP    | holding the write response until BREADY
module axi_mem_slave
    import axi_mem_slave_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int ADDR_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] ARADDR,
    input  logic                 ARVALID,
    output logic                 ARREADY,
    input  logic [7:0]           ARLEN,
    input  logic [2:0]           ARSIZE,
    output logic                 RVALID,
    output logic [31:0]          RDATA,
    input  logic                 RREADY,
    output logic                 RLAST,
    input  logic [ADDR_BITS-1:0] AWADDR,
    input  logic                 AWVALID,
    output logic                 AWREADY,
    input  logic [7:0]           AWLEN,
    input  logic [2:0]           AWSIZE,
    input  logic                 WVALID,
    output logic                 WREADY,
    input  logic [31:0]          WDATA,
    input  logic                 WLAST,
    output logic                 BVALID,
    input  logic                 BREADY,
    output logic [1:0]           BRESP
);

    state_e            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [8:0]        cnt_q;
    logic              err_q;
    logic              arready_q;
    logic              awready_q;
    logic              rvalid_q;
    logic              rlast_q;
    logic              wready_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q;

    logic [ADDR_W-1:0] ar_idx;
    logic [ADDR_W-1:0] aw_idx;
    logic [ADDR_W-1:0] rd_idx_d;
    logic              aw_hs;
    logic              ar_hs;
    logic              r_hs;
    logic              w_hs;
    logic              w_final;
    logic              w_err;
    logic              ram_we;
    logic              ram_re;
    logic [31:0]       ram_rdata;

    // Transfer size is always treated as 4 bytes; upper/lower address bits
    // outside the word index are ignored.
    logic unused_ok;
    assign unused_ok = ^{ARSIZE, AWSIZE,
                         ARADDR[ADDR_BITS-1:ADDR_W+2], ARADDR[1:0],
                         AWADDR[ADDR_BITS-1:ADDR_W+2], AWADDR[1:0]};

    assign ar_idx  = ARADDR[ADDR_W+1:2];
    assign aw_idx  = AWADDR[ADDR_W+1:2];

    // AR is masked while AWVALID is up so a tie always resolves to the write.
    assign ARREADY = arready_q && !AWVALID;
    assign AWREADY = awready_q;
    assign aw_hs   = AWVALID && awready_q;
    assign ar_hs   = ARVALID && ARREADY;
    assign r_hs    = rvalid_q && RREADY;
    assign w_hs    = WVALID && wready_q;
    assign w_final = (cnt_q == 9'd1);
    assign w_err   = (WLAST != w_final);

    // Reset aborts a write beat in the same cycle it is asserted.
    assign ram_we   = w_hs && !rst;
    assign ram_re   = ar_hs || r_hs;
    assign rd_idx_d = ar_hs ? ar_idx : idx_q + 1'b1;

    axi_mem_slave_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (idx_q),
        .wdata_i (WDATA),
        .re_i    (ram_re),
        .raddr_i (rd_idx_d),
        .rdata_o (ram_rdata)
    );

    assign RVALID = rvalid_q;
    assign RDATA  = rvalid_q ? ram_rdata : 32'd0;
    assign RLAST  = rlast_q;
    assign WREADY = wready_q;
    assign BVALID = bvalid_q;
    assign BRESP  = bresp_q;

    // Transaction FSM with beat down-counter, word index and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            arready_q <= 1'b0;
            awready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= AXI_RESP_OKAY;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    arready_q <= 1'b1;
                    awready_q <= 1'b1;
                    if (aw_hs) begin
                        state_q   <= ST_WR;
                        idx_q     <= aw_idx;
                        cnt_q     <= {1'b0, AWLEN} + 9'd1;
                        err_q     <= 1'b0;
                        arready_q <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                    end else if (ar_hs) begin
                        state_q   <= ST_RD;
                        idx_q     <= ar_idx;
                        cnt_q     <= {1'b0, ARLEN} + 9'd1;
                        arready_q <= 1'b0;
                        awready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rlast_q   <= (ARLEN == 8'd0);
                    end
                end
                ST_RD: begin
                    if (r_hs) begin
                        if (cnt_q == 9'd1) begin
                            state_q   <= ST_IDLE;
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            awready_q <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            cnt_q   <= cnt_q - 9'd1;
                            rlast_q <= (cnt_q == 9'd2);
                        end
                    end
                end
                ST_WR: begin
                    if (w_hs) begin
                        idx_q <= idx_q + 1'b1;
                        if (w_final) begin
                            state_q  <= ST_RESP;
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= resp_for(err_q || w_err);
                        end else begin
                            cnt_q <= cnt_q - 9'd1;
                            err_q <= err_q || w_err;
                        end
                    end
                end
                ST_RESP: begin
                    if (BREADY) begin
                        state_q   <= ST_IDLE;
                        bvalid_q  <= 1'b0;
                        bresp_q   <= AXI_RESP_OKAY;
                        err_q     <= 1'b0;
                        arready_q <= 1'b1;
                        awready_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Scoreboard bench for axi_mem_slave: stimulus pushes expected read beats
// and write responses; a negedge monitor pops and compares on handshakes.
module tb_axi_mem_slave;

    localparam int ADDR_W = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ARADDR = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [7:0]  ARLEN = '0;
    logic [2:0]  ARSIZE = 3'd2;
    logic        RVALID;
    logic [31:0] RDATA;
    logic        RREADY = 1'b1;
    logic        RLAST;
    logic [31:0] AWADDR = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [7:0]  AWLEN = '0;
    logic [2:0]  AWSIZE = 3'd2;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [31:0] WDATA = '0;
    logic        WLAST = 1'b0;
    logic        BVALID;
    logic        BREADY = 1'b1;
    logic [1:0]  BRESP;

    always #5 clk = ~clk;

    axi_mem_slave #(.ADDR_W(ADDR_W), .ADDR_BITS(32)) dut (
        .clk(clk), .rst(rst),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .RVALID(RVALID), .RDATA(RDATA), .RREADY(RREADY), .RLAST(RLAST),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } rbeat_t;

    rbeat_t      exp_r[$];
    logic [1:0]  exp_b[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] wd[16];
    logic        wl[16];
    int          ar_b_pending = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: handshake missing or unexpected", name);
    endtask

    // Monitor: checks read beats, stall stability and write responses.
    rbeat_t      e_r;
    logic [1:0]  e_b;
    logic        stall_q = 1'b0;
    logic [31:0] stall_data = '0;
    logic        stall_last = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("r_stall_valid", 32'(RVALID), 32'd1);
                check("r_stall_data", RDATA, stall_data);
                check("r_stall_last", 32'(RLAST), 32'(stall_last));
            end
            if (RVALID && RREADY) begin
                if (exp_r.size() == 0) begin
                    fail("r_unexpected");
                end else begin
                    e_r = exp_r.pop_front();
                    check("r_data", RDATA, e_r.data);
                    check("r_last", 32'(RLAST), 32'(e_r.last));
                end
            end
            if (BVALID && BREADY) begin
                if (exp_b.size() == 0) begin
                    fail("b_unexpected");
                end else begin
                    e_b = exp_b.pop_front();
                    check("b_resp", 32'(BRESP), 32'(e_b));
                end
            end
            stall_q    = RVALID && !RREADY;
            stall_data = RDATA;
            stall_last = RLAST;
        end
    end

    task automatic do_aw(input logic [31:0] a, input logic [7:0] l);
        bit hs;
        hs = 1'b0;
        AWADDR = a; AWLEN = l; AWSIZE = 3'd2; AWVALID = 1'b1;
        for (int i = 0; i < 100 && !hs; i++) begin
            @(negedge clk);
            hs = AWREADY;
            @(posedge clk); #1;
        end
        AWVALID = 1'b0;
        if (!hs) fail("aw_timeout");
    endtask

    task automatic do_ar(input logic [31:0] a, input logic [7:0] l);
        bit hs;
        hs = 1'b0;
        ARADDR = a; ARLEN = l; ARSIZE = 3'd2; ARVALID = 1'b1;
        for (int i = 0; i < 100 && !hs; i++) begin
            @(negedge clk);
            hs = ARREADY;
            if (hs) ar_b_pending = exp_b.size();
            @(posedge clk); #1;
        end
        ARVALID = 1'b0;
        if (!hs) fail("ar_timeout");
    endtask

    task automatic do_w(input int n);
        bit hs;
        for (int b = 0; b < n; b++) begin
            hs = 1'b0;
            WDATA = wd[b]; WLAST = wl[b]; WVALID = 1'b1;
            for (int i = 0; i < 100 && !hs; i++) begin
                @(negedge clk);
                hs = WREADY;
                @(posedge clk); #1;
            end
            if (!hs) fail("w_timeout");
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
    endtask

    task automatic wait_r(input bit toggle);
        int i;
        i = 0;
        while (exp_r.size() != 0 && i < 300) begin
            @(posedge clk); #1;
            if (toggle) RREADY = ~RREADY;
            i++;
        end
        RREADY = 1'b1;
        if (exp_r.size() != 0) begin
            fail("r_timeout");
            exp_r.delete();
        end
    endtask

    task automatic wait_b();
        int i;
        i = 0;
        while (exp_b.size() != 0 && i < 100) begin
            @(posedge clk); #1;
            i++;
        end
        if (exp_b.size() != 0) begin
            fail("b_timeout");
            exp_b.delete();
        end
    endtask

    task automatic write_burst(input logic [31:0] a, input int n, input logic [1:0] resp);
        exp_b.push_back(resp);
        do_aw(a, 8'(n - 1));
        do_w(n);
        wait_b();
    endtask

    task automatic push_r(input logic [31:0] d, input logic last);
        rbeat_t b;
        b.data = d;
        b.last = last;
        exp_r.push_back(b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held two cycles: every output low.
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_arready", 32'(ARREADY), 32'd0);
            check("rst_awready", 32'(AWREADY), 32'd0);
            check("rst_rvalid",  32'(RVALID),  32'd0);
            check("rst_rlast",   32'(RLAST),   32'd0);
            check("rst_wready",  32'(WREADY),  32'd0);
            check("rst_bvalid",  32'(BVALID),  32'd0);
            check("rst_bresp",   32'(BRESP),   32'd0);
            check("rst_rdata",   RDATA,        32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle_arready", 32'(ARREADY), 32'd1);
        check("idle_awready", 32'(AWREADY), 32'd1);
        @(posedge clk); #1;

        // Basic 4-beat write then read back.
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        wl[0] = 0; wl[1] = 0; wl[2] = 0; wl[3] = 1;
        write_burst(32'h40, 4, 2'b00);
        push_r(32'h11, 0); push_r(32'h22, 0); push_r(32'h33, 0); push_r(32'h44, 1);
        do_ar(32'h40, 8'd3);
        wait_r(1'b0);

        // 8-beat burst read back with RREADY toggling every cycle.
        for (int i = 0; i < 8; i++) begin
            wd[i] = 32'hA0 + 32'(i);
            wl[i] = (i == 7);
        end
        write_burst(32'h100, 8, 2'b00);
        for (int i = 0; i < 8; i++) push_r(32'hA0 + 32'(i), (i == 7));
        RREADY = 1'b1;
        do_ar(32'h100, 8'd7);
        wait_r(1'b1);

        // Same-cycle AW and AR: write wins, read sees new data after BRESP.
        wd[0] = 32'hDEADBEEF; wl[0] = 1;
        exp_b.push_back(2'b00);
        push_r(32'hDEADBEEF, 1);
        ar_b_pending = -1;
        fork
            begin
                do_aw(32'h200, 8'd0);
                do_w(1);
            end
            do_ar(32'h200, 8'd0);
            begin
                @(negedge clk);
                check("tie_arready", 32'(ARREADY), 32'd0);
                check("tie_awready", 32'(AWREADY), 32'd1);
            end
        join
        wait_b();
        wait_r(1'b0);
        check("ar_after_b", 32'(ar_b_pending), 32'd0);

        // Early WLAST on a 2-beat write: both beats land, SLVERR response.
        wd[0] = 32'h55; wd[1] = 32'h66; wl[0] = 1; wl[1] = 0;
        write_burst(32'h300, 2, 2'b10);
        push_r(32'h55, 0); push_r(32'h66, 1);
        do_ar(32'h300, 8'd1);
        wait_r(1'b0);

        // Index wrap from the top word to word 0.
        wd[0] = 32'h77; wd[1] = 32'h88; wl[0] = 0; wl[1] = 1;
        write_burst(32'hFFC, 2, 2'b00);
        push_r(32'h88, 1);
        do_ar(32'h0, 8'd0);
        wait_r(1'b0);
        push_r(32'h77, 0); push_r(32'h88, 1);
        do_ar(32'hFFC, 8'd1);
        wait_r(1'b0);

        // Reset while beat 2 of a read is stalled, then a fresh read.
        push_r(32'h11, 0);
        RREADY = 1'b1;
        do_ar(32'h40, 8'd3);
        @(posedge clk); #1;
        RREADY = 1'b0;
        @(negedge clk);
        check("pre_rst_rvalid", 32'(RVALID), 32'd1);
        check("pre_rst_rdata", RDATA, 32'h22);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_rvalid", 32'(RVALID), 32'd0);
        check("abort_rlast", 32'(RLAST), 32'd0);
        check("abort_rq_empty", 32'(exp_r.size()), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        RREADY = 1'b1;
        push_r(32'h11, 0); push_r(32'h22, 0); push_r(32'h33, 0); push_r(32'h44, 1);
        do_ar(32'h40, 8'd3);
        wait_r(1'b0);

        repeat (3) @(posedge clk);
        check("end_rq_empty", 32'(exp_r.size()), 32'd0);
        check("end_bq_empty", 32'(exp_b.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
